// File: rtl/axi_stream_fork_pkg.sv
// ---------------------------------------------------------------------------
// axi_stream_fork_pkg
// Shared constants and helpers for the AXI-stream fork.
//   DROP_CNT_W / DROP_CNT_MAX : width and saturation value of the drop counter
//   ptr_w()                   : FIFO pointer width for a given depth (min 1)
// ---------------------------------------------------------------------------
package axi_stream_fork_pkg;

  localparam int DROP_CNT_W = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/axi_fork_fifo.sv
// ---------------------------------------------------------------------------
// axi_fork_fifo
// One per-output buffer of the stream fork: a DEPTH-entry FIFO whose head is
// presented as an AXI-stream master.
// Ports:
//   aclk, aresetn  clock, async active-low reset (pointers/count only)
//   push           write push_data this cycle (never asserted while full)
//   push_data      entry to write
//   full           count == DEPTH
//   m_valid        FIFO not empty
//   m_ready        downstream ready; m_valid & m_ready pops the head
//   m_data         head entry
// ---------------------------------------------------------------------------
module axi_fork_fifo
  import axi_stream_fork_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // A single-entry buffer cannot sustain one beat per cycle.
  if (DEPTH < 2) begin : g_depth_chk
    $error("axi_fork_fifo: DEPTH must be >= 2");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pop;

  // Explicit wrap so non-power-of-2 depths never index past DEPTH-1.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_FULL);
  assign m_valid = (count_q != '0);
  assign m_data  = mem_q[rd_ptr_q];
  assign pop     = m_valid & m_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ptr_next(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_next(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; valid is governed by count_q alone.
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/axi_stream_fork.sv
// ---------------------------------------------------------------------------
// axi_stream_fork
// Broadcasts one AXI-stream source to N_OUTPUTS buffered destinations. A
// per-beat mask selects which outputs receive the beat; each output drains
// from its own FIFO independently.
// Ports:
//   aclk, aresetn  clock, async active-low reset
//   s_valid/s_ready/s_data/s_mask  source beat and destination mask
//   m_valid/m_ready  per-output handshake
//   m_data           output i at [i*DATA_W +: DATA_W]
//   drop_cnt         saturating count of accepted beats with an all-zero mask
// ---------------------------------------------------------------------------
module axi_stream_fork
  import axi_stream_fork_pkg::*;
#(
  parameter int N_OUTPUTS = 2,
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 2
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_W-1:0]           s_data,
  input  logic [N_OUTPUTS-1:0]        s_mask,
  output logic [N_OUTPUTS-1:0]        m_valid,
  input  logic [N_OUTPUTS-1:0]        m_ready,
  output logic [N_OUTPUTS*DATA_W-1:0] m_data,
  output logic [DROP_CNT_W-1:0]       drop_cnt
);

  logic [N_OUTPUTS-1:0]  full;
  logic [N_OUTPUTS-1:0]  push;
  logic                  accept;
  logic                  drop;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Any full FIFO stalls the source, even one the next beat would skip;
  // this keeps s_ready free of any path from s_mask.
  assign s_ready = &(~full);
  assign accept  = s_valid & s_ready;
  assign push    = {N_OUTPUTS{accept}} & s_mask;
  assign drop    = accept & (s_mask == '0);

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != DROP_CNT_MAX)) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) drop_cnt_q <= '0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;

  for (genvar i = 0; i < N_OUTPUTS; i++) begin : g_out
    axi_fork_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .push      (push[i]),
      .push_data (s_data),
      .full      (full[i]),
      .m_valid   (m_valid[i]),
      .m_ready   (m_ready[i]),
      .m_data    (m_data[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_axi_stream_fork.sv
module tb_axi_stream_fork;

  localparam int W = 16;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;

  logic         s_valid, s_ready;
  logic [W-1:0] s_data;
  logic [1:0]   s_mask, m_valid, m_ready;
  logic [2*W-1:0] m_data;
  logic [15:0]  drop_cnt;

  logic         s_valid3, s_ready3;
  logic [W-1:0] s_data3;
  logic [1:0]   s_mask3, m_valid3, m_ready3;
  logic [2*W-1:0] m_data3;
  logic [15:0]  drop_cnt3;

  int n_err = 0;
  int n_chk = 0;

  axi_stream_fork #(.N_OUTPUTS(2), .DATA_W(W), .DEPTH(2)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_mask(s_mask),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .drop_cnt(drop_cnt)
  );

  axi_stream_fork #(.N_OUTPUTS(2), .DATA_W(W), .DEPTH(3)) dut3 (
    .aclk(aclk), .aresetn(aresetn),
    .s_valid(s_valid3), .s_ready(s_ready3), .s_data(s_data3), .s_mask(s_mask3),
    .m_valid(m_valid3), .m_ready(m_ready3), .m_data(m_data3), .drop_cnt(drop_cnt3)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [15:0]  r0_pat, r1_pat;
  int           sent;
  logic         mdl_rdy, acc;

  initial begin
    s_valid = 0; s_data = '0; s_mask = '0; m_ready = '0;
    s_valid3 = 0; s_data3 = '0; s_mask3 = '0; m_ready3 = '0;

    repeat (2) step();
    chk("rst_s_ready_during", {31'd0, s_ready}, 32'd1);
    chk("rst_m_valid_during", {30'd0, m_valid}, 32'd0);
    aresetn = 1'b1;
    step();
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("rst_m_valid", {30'd0, m_valid}, 32'd0);
    chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    chk("rst3_m_valid", {30'd0, m_valid3}, 32'd0);

    // Broadcast 1..8 back-to-back, both outputs always ready.
    m_ready = 2'b11; s_valid = 1; s_mask = 2'b11;
    for (int k = 0; k < 8; k++) begin
      s_data = W'(k + 1);
      step();
      chk("bc_m_valid", {30'd0, m_valid}, 32'd3);
      chk("bc_data0", {16'd0, m_data[W-1:0]}, k + 1);
      chk("bc_data1", {16'd0, m_data[2*W-1:W]}, k + 1);
      chk("bc_s_ready", {31'd0, s_ready}, 32'd1);
    end
    s_valid = 0;
    step();
    chk("bc_drained", {30'd0, m_valid}, 32'd0);

    // Stalled output 1.
    m_ready = 2'b01; s_valid = 1; s_mask = 2'b11; s_data = 16'h0011;
    step();
    chk("st_m_valid_a", {30'd0, m_valid}, 32'd3);
    chk("st_data0_a", {16'd0, m_data[W-1:0]}, 32'h11);
    s_data = 16'h0012;
    step();
    chk("st_s_ready_low", {31'd0, s_ready}, 32'd0);
    chk("st_data0_b", {16'd0, m_data[W-1:0]}, 32'h12);
    chk("st_data1_b", {16'd0, m_data[2*W-1:W]}, 32'h11);
    s_data = 16'h0013;
    step();
    chk("st_m_valid_c", {30'd0, m_valid}, 32'd2);
    chk("st_s_ready_c", {31'd0, s_ready}, 32'd0);
    m_ready = 2'b11;
    step();
    chk("st_s_ready_back", {31'd0, s_ready}, 32'd1);
    chk("st_m_valid_d", {30'd0, m_valid}, 32'd2);
    chk("st_data1_d", {16'd0, m_data[2*W-1:W]}, 32'h12);
    step();
    chk("st_m_valid_e", {30'd0, m_valid}, 32'd3);
    chk("st_data0_e", {16'd0, m_data[W-1:0]}, 32'h13);
    chk("st_data1_e", {16'd0, m_data[2*W-1:W]}, 32'h13);
    s_valid = 0;
    step();
    chk("st_drained", {30'd0, m_valid}, 32'd0);

    // Multicast masks 01,10,11,01 with A,B,C,D.
    s_valid = 1;
    s_mask = 2'b01; s_data = 16'hAAAA;
    step();
    chk("mc_valid_a", {30'd0, m_valid}, 32'd1);
    chk("mc_data0_a", {16'd0, m_data[W-1:0]}, 32'hAAAA);
    s_mask = 2'b10; s_data = 16'hBBBB;
    step();
    chk("mc_valid_b", {30'd0, m_valid}, 32'd2);
    chk("mc_data1_b", {16'd0, m_data[2*W-1:W]}, 32'hBBBB);
    s_mask = 2'b11; s_data = 16'hCCCC;
    step();
    chk("mc_valid_c", {30'd0, m_valid}, 32'd3);
    chk("mc_data0_c", {16'd0, m_data[W-1:0]}, 32'hCCCC);
    chk("mc_data1_c", {16'd0, m_data[2*W-1:W]}, 32'hCCCC);
    s_mask = 2'b01; s_data = 16'hDDDD;
    step();
    chk("mc_valid_d", {30'd0, m_valid}, 32'd1);
    chk("mc_data0_d", {16'd0, m_data[W-1:0]}, 32'hDDDD);
    s_valid = 0;
    step();
    chk("mc_drained", {30'd0, m_valid}, 32'd0);
    chk("mc_drop_cnt", {16'd0, drop_cnt}, 32'd0);

    // Zero mask: accepted, discarded, counted, saturating.
    s_valid = 1; s_mask = 2'b00; s_data = 16'h5555;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("zm_m_valid", {30'd0, m_valid}, 32'd0);
      chk("zm_s_ready", {31'd0, s_ready}, 32'd1);
    end
    chk("zm_drop_3", {16'd0, drop_cnt}, 32'd3);
    for (int k = 3; k < 65534; k++) step();
    chk("zm_drop_fffe", {16'd0, drop_cnt}, 32'hFFFE);
    step();
    chk("zm_drop_ffff", {16'd0, drop_cnt}, 32'hFFFF);
    repeat (3) step();
    chk("zm_drop_sat", {16'd0, drop_cnt}, 32'hFFFF);
    s_valid = 0;

    // DEPTH=3 with scripted ready patterns; bench-side queue model.
    r0_pat = 16'b1011_0010_1100_1101;
    r1_pat = 16'b0110_1101_0110_0000;
    sent = 0;
    s_mask3 = 2'b11;
    for (int c = 0; c < 40; c++) begin
      chk("d3_m_valid0", {31'd0, m_valid3[0]}, {31'd0, q0.size() != 0});
      chk("d3_m_valid1", {31'd0, m_valid3[1]}, {31'd0, q1.size() != 0});
      if (q0.size() != 0) chk("d3_data0", {16'd0, m_data3[W-1:0]}, {16'd0, q0[0]});
      if (q1.size() != 0) chk("d3_data1", {16'd0, m_data3[2*W-1:W]}, {16'd0, q1[0]});
      mdl_rdy = (q0.size() < 3) && (q1.size() < 3);
      chk("d3_s_ready", {31'd0, s_ready3}, {31'd0, mdl_rdy});
      s_valid3 = (sent < 10);
      s_data3  = W'(16'h0040 + sent);
      if (c < 16) m_ready3 = {r1_pat[c], r0_pat[c]};
      else        m_ready3 = 2'b11;
      acc = s_valid3 && mdl_rdy;
      if (q0.size() != 0 && m_ready3[0]) void'(q0.pop_front());
      if (q1.size() != 0 && m_ready3[1]) void'(q1.pop_front());
      if (acc) begin
        q0.push_back(s_data3);
        q1.push_back(s_data3);
        sent++;
      end
      step();
    end
    s_valid3 = 0;
    chk("d3_all_sent", sent, 32'd10);
    chk("d3_drained", {30'd0, m_valid3}, 32'd0);

    // Reset mid-stream with two beats buffered.
    m_ready = 2'b00; s_valid = 1; s_mask = 2'b11;
    s_data = 16'h0021;
    step();
    s_data = 16'h0022;
    step();
    s_valid = 0;
    chk("mr_full", {31'd0, s_ready}, 32'd0);
    chk("mr_buffered", {30'd0, m_valid}, 32'd3);
    aresetn = 1'b0;
    #1;
    chk("mr_m_valid_in", {30'd0, m_valid}, 32'd0);
    chk("mr_s_ready_in", {31'd0, s_ready}, 32'd1);
    chk("mr_drop_in", {16'd0, drop_cnt}, 32'd0);
    step();
    chk("mr_m_valid_hold", {30'd0, m_valid}, 32'd0);
    aresetn = 1'b1;
    step();
    chk("mr_m_valid_after", {30'd0, m_valid}, 32'd0);
    chk("mr_s_ready_after", {31'd0, s_ready}, 32'd1);
    chk("mr_drop_after", {16'd0, drop_cnt}, 32'd0);
    m_ready = 2'b11; s_valid = 1; s_data = 16'h0031;
    step();
    chk("mr_new_valid", {30'd0, m_valid}, 32'd3);
    chk("mr_new_data0", {16'd0, m_data[W-1:0]}, 32'h31);
    chk("mr_new_data1", {16'd0, m_data[2*W-1:W]}, 32'h31);
    s_valid = 0;
    step();
    chk("mr_new_drained", {30'd0, m_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
